// File: rtl/mips_defs.sv
// Shared MIPS multicycle definitions: opcodes, ALU operation classes, mux selects and
// main-decoder state codes, used by maindec, aludec and the datapath.
package mips_defs;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   // aluop classes; aludec decodes funct only for ALUOP_FUNCT
   localparam logic [2:0] ALUOP_ADD   = 3'b000;
   localparam logic [2:0] ALUOP_OR    = 3'b001;
   localparam logic [2:0] ALUOP_FUNCT = 3'b100;
   localparam logic [2:0] ALUOP_BEQ   = 3'b110;
   localparam logic [2:0] ALUOP_BNE   = 3'b111;

   localparam logic [1:0] SRCB_REG   = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   localparam logic [3:0] S_FETCH   = 4'd0;
   localparam logic [3:0] S_DECODE  = 4'd1;
   localparam logic [3:0] S_MEMADR  = 4'd2;
   localparam logic [3:0] S_MEMRD   = 4'd3;
   localparam logic [3:0] S_MEMWB   = 4'd4;
   localparam logic [3:0] S_MEMWR   = 4'd5;
   localparam logic [3:0] S_RTYPEEX = 4'd6;
   localparam logic [3:0] S_ALUWB   = 4'd7;
   localparam logic [3:0] S_BEQEX   = 4'd8;
   localparam logic [3:0] S_BNEEX   = 4'd9;
   localparam logic [3:0] S_ADDIEX  = 4'd10;
   localparam logic [3:0] S_ORIEX   = 4'd11;
   localparam logic [3:0] S_IMMWB   = 4'd12;
   localparam logic [3:0] S_JEX     = 4'd13;

   typedef enum logic [3:0] {
      FETCH   = S_FETCH,
      DECODE  = S_DECODE,
      MEMADR  = S_MEMADR,
      MEMRD   = S_MEMRD,
      MEMWB   = S_MEMWB,
      MEMWR   = S_MEMWR,
      RTYPEEX = S_RTYPEEX,
      ALUWB   = S_ALUWB,
      BEQEX   = S_BEQEX,
      BNEEX   = S_BNEEX,
      ADDIEX  = S_ADDIEX,
      ORIEX   = S_ORIEX,
      IMMWB   = S_IMMWB,
      JEX     = S_JEX
   } statetype_t;

endpackage

// File: rtl/maindec_fsm.sv
// Multicycle MIPS main decoder: Moore FSM, outputs decoded from current state only.
// Latency 3-5 cycles per instruction (2 for unknown opcodes); no backpressure, advances every clock.
module maindec_fsm
   import mips_defs::*;
#(
   parameter int STATE_W = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [5:0]         op,
   output logic               pcwrite,
   output logic               memwrite,
   output logic               irwrite,
   output logic               regwrite,
   output logic               alusrca,
   output logic               branch,
   output logic               bne,
   output logic               iord,
   output logic               memtoreg,
   output logic               regdst,
   output logic [1:0]         alusrcb,
   output logic [1:0]         pcsrc,
   output logic [2:0]         aluop,
   output logic [STATE_W-1:0] state
);

   statetype_t cur_state, nxt_state;

   always_ff @(posedge clk) begin
      if (reset) cur_state <= FETCH;
      else       cur_state <= nxt_state;
   end

   assign state = STATE_W'(cur_state);

   always_comb begin
      nxt_state = FETCH;
      pcwrite   = 1'b0;
      memwrite  = 1'b0;
      irwrite   = 1'b0;
      regwrite  = 1'b0;
      alusrca   = 1'b0;
      branch    = 1'b0;
      bne       = 1'b0;
      iord      = 1'b0;
      memtoreg  = 1'b0;
      regdst    = 1'b0;
      alusrcb   = SRCB_REG;
      pcsrc     = PCSRC_ALU;
      aluop     = ALUOP_ADD;

      case (cur_state)
         FETCH: begin
            irwrite   = 1'b1;
            pcwrite   = 1'b1;
            alusrcb   = SRCB_FOUR;
            nxt_state = DECODE;
         end
         DECODE: begin
            // branch target is precomputed here so BEQEX/BNEEX can take it from ALUOut
            alusrcb = SRCB_IMMSH;
            case (op)
               OP_LW, OP_SW: nxt_state = MEMADR;
               OP_RTYPE:     nxt_state = RTYPEEX;
               OP_BEQ:       nxt_state = BEQEX;
               OP_BNE:       nxt_state = BNEEX;
               OP_ADDI:      nxt_state = ADDIEX;
               OP_ORI:       nxt_state = ORIEX;
               OP_J:         nxt_state = JEX;
               default:      nxt_state = FETCH;
            endcase
         end
         MEMADR: begin
            alusrca   = 1'b1;
            alusrcb   = SRCB_IMM;
            nxt_state = (op == OP_LW) ? MEMRD : MEMWR;
         end
         MEMRD: begin
            iord      = 1'b1;
            nxt_state = MEMWB;
         end
         MEMWB: begin
            memtoreg = 1'b1;
            regwrite = 1'b1;
         end
         MEMWR: begin
            iord     = 1'b1;
            memwrite = 1'b1;
         end
         RTYPEEX: begin
            alusrca   = 1'b1;
            aluop     = ALUOP_FUNCT;
            nxt_state = ALUWB;
         end
         ALUWB: begin
            regdst   = 1'b1;
            regwrite = 1'b1;
         end
         BEQEX: begin
            alusrca = 1'b1;
            aluop   = ALUOP_BEQ;
            pcsrc   = PCSRC_ALUOUT;
            branch  = 1'b1;
         end
         BNEEX: begin
            alusrca = 1'b1;
            aluop   = ALUOP_BNE;
            pcsrc   = PCSRC_ALUOUT;
            bne     = 1'b1;
         end
         ADDIEX: begin
            alusrca   = 1'b1;
            alusrcb   = SRCB_IMM;
            nxt_state = IMMWB;
         end
         ORIEX: begin
            alusrca   = 1'b1;
            alusrcb   = SRCB_IMM;
            aluop     = ALUOP_OR;
            nxt_state = IMMWB;
         end
         IMMWB: begin
            regwrite = 1'b1;
         end
         JEX: begin
            pcsrc   = PCSRC_JUMP;
            pcwrite = 1'b1;
         end
         default: nxt_state = FETCH;
      endcase
   end

endmodule

// File: doc/maindec_fsm.md
MAINDEC_FSM -- requirements
Module: maindec_fsm

Interface
REQ-001 Parameter: STATE_W, 4, width of the state register.
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: reset  input  1  reset; one clock, reset is synchronous and active-high.
REQ-004 Port: op  input  6  opcode field of the instruction register.
REQ-005 Ports, each output 1 bit: pcwrite, memwrite, irwrite, regwrite, alusrca, branch, bne, iord, memtoreg, regdst (multicycle datapath enables and selects).
REQ-006 Port: alusrcb  output  2  ALU B select: 00 reg, 01 const 4, 10 imm, 11 imm<<2.
REQ-007 Port: pcsrc  output  2  PC select: 00 ALU result, 01 ALUOut, 10 jump target.
REQ-008 Port: aluop  output  3  ALU operation class: 000 add, 001 or, 100 R-type funct, 110 beq compare, 111 bne compare.
REQ-009 Port: state  output  STATE_W  current state code, for debug.

Function
REQ-010 The block SHALL be a Moore FSM; every output SHALL be a pure function of the current state. Outputs not listed for a state SHALL be 0.
REQ-011 States and outputs SHALL be:
- FETCH: iord=0, alusrca=0, alusrcb=01, aluop=000, pcsrc=00, irwrite=1, pcwrite=1
- DECODE: alusrca=0, alusrcb=11, aluop=000
- MEMADR: alusrca=1, alusrcb=10, aluop=000
- MEMRD: iord=1
- MEMWB: regdst=0, memtoreg=1, regwrite=1
- MEMWR: iord=1, memwrite=1
- RTYPEEX: alusrca=1, alusrcb=00, aluop=100
- ALUWB: regdst=1, memtoreg=0, regwrite=1
- BEQEX: alusrca=1, alusrcb=00, aluop=110, pcsrc=01, branch=1
- BNEEX: alusrca=1, alusrcb=00, aluop=111, pcsrc=01, bne=1
- ADDIEX: alusrca=1, alusrcb=10, aluop=000
- ORIEX: alusrca=1, alusrcb=10, aluop=001
- IMMWB: regdst=0, memtoreg=0, regwrite=1
- JEX: pcsrc=10, pcwrite=1
REQ-012 Transitions SHALL be:
- FETCH->DECODE.
- DECODE dispatches on op: 100011 lw or 101011 sw->MEMADR; 000000->RTYPEEX; 000100->BEQEX; 000101->BNEEX; 001000->ADDIEX; 001101->ORIEX; 000010->JEX.
- MEMADR: op=100011->MEMRD, otherwise->MEMWR.
- MEMRD->MEMWB.
- RTYPEEX->ALUWB.
- ADDIEX and ORIEX->IMMWB.
- MEMWB, MEMWR, ALUWB, IMMWB, BEQEX, BNEEX and JEX->FETCH.
REQ-013 An unlisted opcode in DECODE SHALL return to FETCH with no register or memory write.
REQ-014 op SHALL be sampled only in DECODE and MEMADR. Changes of op in other states SHALL have no effect.
REQ-015 Instruction latency including FETCH SHALL be: lw 5, sw 4, R-type 4, addi/ori 4, beq/bne 3, j 3 cycles.
REQ-016 Any unused state code SHALL transition to FETCH on the next clock.
REQ-017 Exactly one of regwrite, memwrite or pcwrite-outside-FETCH SHALL be asserted per instruction, except beq/bne, which assert none.

Reset
REQ-018 reset high at a clock edge SHALL force state to FETCH, from any state including mid-instruction. Outputs SHALL equal the FETCH values in the cycle after that edge.
REQ-019 While reset is held high, the state SHALL remain FETCH. No MEMWR or writeback state SHALL be entered.

Structure
REQ-020 The state encodings (4-bit localparams) and opcode constants SHALL live in a shared package, mips_defs, reused by the datapath and aludec.
REQ-021 The aluop codes SHALL be package constants matching the aludec consumer.
REQ-022 No sub-module is required; the state register and next-state/output logic SHALL reside in maindec_fsm.

Verification
REQ-023 reset=1 for 2 cycles, then 0 -> state=FETCH, pcwrite=1, irwrite=1, alusrcb=01, aluop=000.
REQ-024 op=100011 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; regwrite=1 and memtoreg=1 only in cycle 5; then back to FETCH.
REQ-025 op=101011 -> FETCH, DECODE, MEMADR, MEMWR; memwrite=1 in cycle 4 only. op=000000 -> aluop=100 in RTYPEEX, then regdst=1 and regwrite=1.
REQ-026 op=000100, then op=000101 -> BEQEX with aluop=110 and branch=1; BNEEX with aluop=111 and bne=1; each returns to FETCH after 3 cycles.
REQ-027 op=001101 -> ORIEX with aluop=001, then IMMWB with regwrite=1. op=111111 -> DECODE->FETCH with no writes.
REQ-028 reset asserted in MEMRD -> next state FETCH, and MEMWB is never entered.
